float_to_int: RTL and testbench

Multi-cycle converter from the coprocessor's internal `float` format (sign, NE-bit exponent, NM-bit mantissa, hidden leading 1) to a two's-complement integer. It is the reverse of the integer-to-float path: it returns coprocessor results to the LM32 integer register file.

- Uses a bit-serial shifter, one position per cycle, to keep area small.
- Uses a start/done handshake.
- Flushes denormals to zero, matching the rest of the float arithmetic.

---
 rtl/float_to_int.sv | 185 ++++++++++++++++++
 tb/tb_float_to_int.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/float_to_int.sv
// float_to_int
//
// Converts the coprocessor's internal float format {sign, exponent, mantissa}
// (hidden leading 1, denormals flushed to zero) into a two's-complement
// integer. A bit-serial shifter moves the significand one position per
// cycle, so a conversion takes |e-NM|+1 cycles; special cases take one.
//
// Optional feature: define F2I_ROUND_EN for round-to-nearest-even on the
// magnitude. Without it, results are truncated toward zero and no rounding
// adder exists.
//
// Handshake: start_i is accepted on any edge where busy_o=0 (IDLE or DONE).
// busy_o is high while a conversion is in flight. done_o pulses high for one
// cycle when result_o/overflow_o/inexact_o carry a new value. Those outputs
// then hold until the next done_o.
//
// Ports:
//   clk_i       clock
//   rst_i       synchronous reset, active-high
//   start_i     conversion request, ignored while busy_o=1
//   op_i        operand {sign, exponent[NE-1:0], mantissa[NM-1:0]}
//   busy_o      conversion in progress
//   done_o      one-cycle result-valid pulse
//   result_o    integer result
//   overflow_o  saturation occurred
//   inexact_o   a nonzero fraction was discarded
module float_to_int #(
    parameter int NM = 23,
    parameter int NE = 8,
    parameter int NI = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [NE+NM:0]   op_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [NI-1:0]    result_o,
    output logic             overflow_o,
    output logic             inexact_o
);

    localparam int EW   = NE + 2;
    localparam int BIAS = 2 ** (NE - 1) - 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [NI-1:0] SAT_POS = {1'b0, {(NI-1){1'b1}}};
    localparam logic [NI-1:0] SAT_NEG = {1'b1, {(NI-1){1'b0}}};

    logic [1:0]    state_q;
    logic [NI-1:0] acc_q;
    logic [EW-1:0] cnt_q;
    logic          left_q;
    logic          sign_q;
    logic          guard_q;
    logic          sticky_q;
    logic          ovf_q;

    // Operand fields and unbiased exponent.
    logic                 op_sign;
    logic [NE-1:0]        op_exp;
    logic [NM-1:0]        op_man;
    logic signed [EW-1:0] e_s;
    logic signed [EW-1:0] diff_s;

    assign op_sign = op_i[NE+NM];
    assign op_exp  = op_i[NE+NM-1:NM];
    assign op_man  = op_i[NM-1:0];
    assign e_s     = $signed({2'b00, op_exp}) - $signed(EW'(BIAS));
    assign diff_s  = e_s - $signed(EW'(NM));

    // Classification of the operand at capture time.
    logic [NI-1:0] cap_acc;
    logic [EW-1:0] cap_cnt;
    logic          cap_left;
    logic          cap_guard;
    logic          cap_sticky;
    logic          cap_ovf;

    always_comb begin
        cap_acc    = '0;
        cap_cnt    = '0;
        cap_left   = 1'b0;
        cap_guard  = 1'b0;
        cap_sticky = 1'b0;
        cap_ovf    = 1'b0;
        if (op_exp == '0) begin
            // Zero or denormal: exact zero.
            cap_acc = '0;
        end else if (op_exp == '1 || e_s > $signed(EW'(NI - 2))) begin
            // Saturate. The magnitude is preloaded so that the common
            // negation step produces -2^(NI-1) for negative operands.
            cap_acc = op_sign ? SAT_NEG : SAT_POS;
            // -2^(NI-1) itself is representable and is not an overflow.
            cap_ovf = !(op_sign && e_s == $signed(EW'(NI - 1)) && op_man == '0);
        end else if (e_s[EW-1]) begin
            // |value| < 1. For e=-1 the hidden bit sits right below the
            // binary point, so it becomes the guard bit; anything smaller
            // only contributes to sticky.
            cap_guard  = &e_s;
            cap_sticky = !(&e_s) || (op_man != '0);
        end else begin
            cap_acc  = NI'({1'b1, op_man});
            cap_left = !diff_s[EW-1];
            cap_cnt  = diff_s[EW-1] ? unsigned'(-diff_s) : unsigned'(diff_s);
        end
    end

    // Magnitude after optional rounding, then sign applied.
    logic [NI-1:0] mag;
    logic [NI-1:0] final_res;

    always_comb begin
`ifdef F2I_ROUND_EN
        mag = acc_q + NI'(guard_q & (sticky_q | acc_q[0]));
`else
        mag = acc_q;
`endif
        final_res = sign_q ? (~mag + NI'(1)) : mag;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            left_q     <= 1'b0;
            sign_q     <= 1'b0;
            guard_q    <= 1'b0;
            sticky_q   <= 1'b0;
            ovf_q      <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            result_o   <= '0;
            overflow_o <= 1'b0;
            inexact_o  <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state_q)
                SHIFT: begin
                    if (cnt_q == '0) begin
                        // All shifting done (or none needed): publish.
                        result_o   <= final_res;
                        overflow_o <= ovf_q;
                        inexact_o  <= guard_q | sticky_q;
                        done_o     <= 1'b1;
                        busy_o     <= 1'b0;
                        state_q    <= DONE;
                    end else begin
                        cnt_q <= cnt_q - EW'(1);
                        if (left_q) begin
                            acc_q <= {acc_q[NI-2:0], 1'b0};
                        end else begin
                            // guard holds the most recent bit shifted out;
                            // older ones collapse into sticky.
                            acc_q    <= {1'b0, acc_q[NI-1:1]};
                            guard_q  <= acc_q[0];
                            sticky_q <= sticky_q | guard_q;
                        end
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new request.
                    if (start_i) begin
                        acc_q    <= cap_acc;
                        cnt_q    <= cap_cnt;
                        left_q   <= cap_left;
                        sign_q   <= op_sign;
                        guard_q  <= cap_guard;
                        sticky_q <= cap_sticky;
                        ovf_q    <= cap_ovf;
                        busy_o   <= 1'b1;
                        state_q  <= SHIFT;
                    end else begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_float_to_int.sv
// Bench for float_to_int with default parameters (NM=23, NE=8, NI=32).
// Directed operands carry hand-computed expectations. A value-level model
// supplies the expectations that the compare process checks on every done_o.
module tb_float_to_int;

    logic        clk_i;
    logic        rst_i;
    logic        start_i;
    logic [31:0] op_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;
    logic        overflow_o;
    logic        inexact_o;

    float_to_int dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .op_i       (op_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .result_o   (result_o),
        .overflow_o (overflow_o),
        .inexact_o  (inexact_o)
    );

    // ---------------- clock / reset ----------------
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    logic [1:0]  flag_q[$];   // {overflow, inexact}
    int          lat_q[$];
    int          issue_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, expv);
        end
    endtask

    // Value-level model: the operand is sig * 2^(e-23) with sig = {1,mant}.
    // The integer part and remainder come from plain division by 2^k.
    function automatic void model(input logic [31:0] op, output logic [31:0] res,
                                  output logic ovf, output logic inx, output int lat);
        int     ex, e, k;
        logic   s;
        longint sig, mag, rem, half;
        s   = op[31];
        ex  = int'(op[30:23]);
        e   = ex - 127;
        sig = longint'({1'b1, op[22:0]});
        mag = 0;
        ovf = 1'b0;
        inx = 1'b0;
        lat = 1;
        if (ex == 0) begin
            mag = 0;
        end else if (ex == 255 || e > 30) begin
            mag = longint'(1) << 31;
            if (!(s && e == 31 && op[22:0] == 23'd0)) begin
                ovf = 1'b1;
                if (!s) mag = (longint'(1) << 31) - 1;
            end
        end else if (e >= 23) begin
            mag = sig << (e - 23);
            lat = e - 23 + 1;
        end else begin
            k = 23 - e;
            if (k <= 60) begin
                mag  = sig >> k;
                rem  = sig - (mag << k);
                half = longint'(1) << (k - 1);
            end else begin
                mag  = 0;
                rem  = 1;
                half = 2;
            end
            inx = (rem != 0);
`ifdef F2I_ROUND_EN
            if (rem > half || (rem == half && mag[0])) mag = mag + 1;
`endif
            lat = (e >= 0) ? k + 1 : 1;
        end
        if (s) mag = -mag;
        res = mag[31:0];
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk_i) begin
        if (!rst_i && done_o) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done_o=1 want 0");
            end else begin
                logic [31:0] r;
                logic [1:0]  f;
                int          l, is;
                r  = exp_q.pop_front();
                f  = flag_q.pop_front();
                l  = lat_q.pop_front();
                is = issue_q.pop_front();
                chk("result", result_o, r);
                chk("overflow", 32'(overflow_o), 32'(f[1]));
                chk("inexact", 32'(inexact_o), 32'(f[0]));
                chk("latency", 32'(cyc - is), 32'(l));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input logic [31:0] op);
        logic [31:0] r;
        logic        o, x;
        int          l, n;
        n = 0;
        while (busy_o && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        if (busy_o) begin
            total++;
            bad++;
            $display("FAIL issue_timeout: got busy_o=1 want 0");
        end
        model(op, r, o, x, l);
        exp_q.push_back(r);
        flag_q.push_back({o, x});
        lat_q.push_back(l);
        issue_q.push_back(cyc + 1);
        start_i = 1'b1;
        op_i    = op;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy_o) && n < 300) begin
            @(negedge clk_i);
            n++;
        end
        if (exp_q.size() != 0 || busy_o) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got pending=%0d want 0", exp_q.size());
        end
    endtask

    // ---------------- directed vectors ----------------
    localparam int NV = 17;
    logic [31:0] t_op [NV] = '{
        32'h3F800000, 32'h40600000, 32'hC0200000, 32'h4B800001,
        32'h4F000000, 32'hCF000000, 32'h7F800000, 32'h3E800000,
        32'h00000000, 32'h3F000000, 32'h3FC00000, 32'hBF400000,
        32'h4EFFFFFF, 32'hCF000001, 32'h00400000, 32'hC3000000,
        32'h4B000000};
`ifdef F2I_ROUND_EN
    logic [31:0] t_res [NV] = '{
        32'h00000001, 32'h00000004, 32'hFFFFFFFE, 32'h01000002,
        32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h00000000,
        32'h00000000, 32'h00000000, 32'h00000002, 32'hFFFFFFFF,
        32'h7FFFFF80, 32'h80000000, 32'h00000000, 32'hFFFFFF80,
        32'h00800000};
`else
    logic [31:0] t_res [NV] = '{
        32'h00000001, 32'h00000003, 32'hFFFFFFFE, 32'h01000002,
        32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h00000000,
        32'h00000000, 32'h00000000, 32'h00000001, 32'h00000000,
        32'h7FFFFF80, 32'h80000000, 32'h00000000, 32'hFFFFFF80,
        32'h00800000};
`endif
    logic t_ovf [NV] = '{0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    logic t_inx [NV] = '{0, 1, 1, 0, 0, 0, 0, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0};
    int   t_lat [NV] = '{24, 23, 23, 2, 1, 1, 1, 1, 1, 1, 24, 1, 8, 1, 1, 17, 1};

    initial begin
        rst_i   = 1'b1;
        start_i = 1'b0;
        op_i    = 32'h0;
        repeat (3) @(negedge clk_i);
        chk("reset_busy", 32'(busy_o), 32'd0);
        chk("reset_done", 32'(done_o), 32'd0);
        chk("reset_result", result_o, 32'd0);
        chk("reset_overflow", 32'(overflow_o), 32'd0);
        chk("reset_inexact", 32'(inexact_o), 32'd0);
        rst_i = 1'b0;
        @(negedge clk_i);

        // Pin the model against the hand-computed values.
        for (int i = 0; i < NV; i++) begin
            logic [31:0] r;
            logic        o, x;
            int          l;
            model(t_op[i], r, o, x, l);
            chk($sformatf("pin_res[%0d]", i), r, t_res[i]);
            chk($sformatf("pin_ovf[%0d]", i), 32'(o), 32'(t_ovf[i]));
            chk($sformatf("pin_inx[%0d]", i), 32'(x), 32'(t_inx[i]));
            chk($sformatf("pin_lat[%0d]", i), 32'(l), 32'(t_lat[i]));
        end

        // Issued as soon as busy_o drops, so most are back-to-back from DONE.
        for (int i = 0; i < NV; i++) issue(t_op[i]);
        drain();

        // A start during SHIFT must not disturb the conversion in flight.
        issue(32'h40600000);
        repeat (4) @(negedge clk_i);
        start_i = 1'b1;
        op_i    = 32'h40000000;
        @(negedge clk_i);
        start_i = 1'b0;
        drain();

        // Reset during SHIFT: outputs clear and no done_o appears.
        start_i = 1'b1;
        op_i    = 32'h3F800000;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (5) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("midreset_busy", 32'(busy_o), 32'd0);
        chk("midreset_done", 32'(done_o), 32'd0);
        chk("midreset_result", result_o, 32'd0);
        chk("midreset_inexact", 32'(inexact_o), 32'd0);
        rst_i = 1'b0;
        repeat (40) @(negedge clk_i);

        // Normal operation after reset.
        issue(32'hC3000000);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
